// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM encoding, port ids and sizing for the instruction-memory arbiter
package imem_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   localparam logic PORT_F = 1'b0;
   localparam logic PORT_L = 1'b1;
   localparam int IMEM_BYTES_DEF = 4096;
   function automatic logic addr_ok(input logic [31:0] a, input int bytes);
      return a[1:0] == 2'b00 && a <= 32'(bytes - 4);
   endfunction
endpackage

// File: rtl/imem_rr_pick.sv
// imem_rr_pick: two-way round-robin winner; ports f_req/l_req (requests), last_grant (port granted last), valid (someone requests), pick (winning port id)
module imem_rr_pick
   import imem_pkg::*;
(
   input  logic f_req,
   input  logic l_req,
   input  logic last_grant,
   output logic valid,
   output logic pick
);
   assign valid = f_req | l_req;
   // On a tie the port not granted last wins; otherwise the sole requester.
   assign pick = (f_req && l_req) ? (last_grant == PORT_F ? PORT_L : PORT_F) : (l_req ? PORT_L : PORT_F);
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates a read-only fetch port and a read/write loader port onto one instruction memory;
// fetch f_req/f_addr -> f_ack/f_err/f_data, loader l_req/l_we/l_addr/l_wdata -> l_ack/l_err/l_rdata,
// memory Address/D_In/im_cs/im_wr/im_rd with D_Out back, plus busy and wr_count status
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int IMEM_BYTES = IMEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_ack,
   output logic        f_err,
   output logic [31:0] f_data,
   input  logic        l_req,
   input  logic        l_we,
   input  logic [31:0] l_addr,
   input  logic [31:0] l_wdata,
   output logic        l_ack,
   output logic        l_err,
   output logic [31:0] l_rdata,
   output logic [31:0] Address,
   output logic [31:0] D_In,
   output logic        im_cs,
   output logic        im_wr,
   output logic        im_rd,
   input  logic [31:0] D_Out,
   output logic        busy,
   output logic [15:0] wr_count
);
   state_e      state_q, state_d;
   logic        port_q, port_d, we_q, we_d, ok_q, ok_d, last_q, last_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        f_ack_q, f_err_q, l_ack_q, l_err_q, busy_q;
   logic [31:0] f_data_q, l_rdata_q;
   logic [15:0] wr_count_q;
   logic        win_v, win_p;

   imem_rr_pick u_pick (
      .f_req      (f_req),
      .l_req      (l_req),
      .last_grant (last_q),
      .valid      (win_v),
      .pick       (win_p)
   );

   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      we_d    = we_q;
      ok_d    = ok_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (state_q == IDLE) begin
         if (win_v) begin
            port_d  = win_p;
            last_d  = win_p;
            addr_d  = win_p == PORT_L ? l_addr : f_addr;
            we_d    = win_p == PORT_L && l_we;
            wdata_d = win_p == PORT_L ? l_wdata : '0;
            ok_d    = addr_ok(addr_d, IMEM_BYTES);
            state_d = ok_d ? ACCESS : RESP;
         end
      end else begin
         state_d = state_q == ACCESS ? RESP : IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         port_q     <= PORT_F;
         we_q       <= 1'b0;
         ok_q       <= 1'b0;
         last_q     <= PORT_L;
         addr_q     <= '0;
         wdata_q    <= '0;
         f_ack_q    <= 1'b0;
         f_err_q    <= 1'b0;
         l_ack_q    <= 1'b0;
         l_err_q    <= 1'b0;
         busy_q     <= 1'b0;
         f_data_q   <= '0;
         l_rdata_q  <= '0;
         wr_count_q <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         ok_q    <= ok_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         // Acks are registered, so they are decoded from the state being entered.
         f_ack_q <= state_d == RESP && port_d == PORT_F;
         l_ack_q <= state_d == RESP && port_d == PORT_L;
         f_err_q <= state_d == RESP && port_d == PORT_F && !ok_d;
         l_err_q <= state_d == RESP && port_d == PORT_L && !ok_d;
         busy_q  <= state_d != IDLE;
         if (state_q == ACCESS && !we_q && port_q == PORT_F) f_data_q <= D_Out;
         if (state_q == ACCESS && !we_q && port_q == PORT_L) l_rdata_q <= D_Out;
         if (state_q == ACCESS && we_q) wr_count_q <= wr_count_q + 16'd1;
      end
   end

   assign im_cs    = state_q == ACCESS;
   assign im_rd    = im_cs && !we_q;
   assign im_wr    = im_cs && we_q;
   assign Address  = im_cs ? addr_q : '0;
   assign D_In     = im_cs ? wdata_q : '0;
   assign f_ack    = f_ack_q;
   assign f_err    = f_err_q;
   assign f_data   = f_data_q;
   assign l_ack    = l_ack_q;
   assign l_err    = l_err_q;
   assign l_rdata  = l_rdata_q;
   assign busy     = busy_q;
   assign wr_count = wr_count_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized scoreboard bench for imem_arbiter against a transaction-level reference model
module tb_imem_arbiter;
   localparam logic PF = 1'b0;
   localparam logic PL = 1'b1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        f_req, l_req, l_we;
   logic [31:0] f_addr, l_addr, l_wdata;
   logic        f_ack, f_err, l_ack, l_err, im_cs, im_wr, im_rd, busy;
   logic [31:0] f_data, l_rdata, Address, D_In, D_Out;
   logic [15:0] wr_count;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   typedef struct {
      logic        port;
      logic        err;
      logic        chk_data;
      logic [31:0] data;
      logic [15:0] wcnt;
   } exp_t;
   exp_t exp_q[$];

   int          n_chk = 0;
   int          n_fail = 0;
   logic        last_m;
   logic [15:0] wc_m;

   imem_arbiter #(.IMEM_BYTES(4096)) dut (
      .clk(clk), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_data(f_data),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_ack(l_ack), .l_err(l_err), .l_rdata(l_rdata),
      .Address(Address), .D_In(D_In), .im_cs(im_cs), .im_wr(im_wr), .im_rd(im_rd),
      .D_Out(D_Out), .busy(busy), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   assign D_Out = mem[Address[11:2]];
   always @(posedge clk) if (im_wr) mem[Address[11:2]] <= D_In;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit addr_valid(input logic [31:0] a);
      return a % 4 == 0 && a <= 32'd4092;
   endfunction

   task automatic push_exp(input logic p, input logic [31:0] a, input logic we, input logic [31:0] wd);
      exp_t e;
      bit ok;
      ok = addr_valid(a);
      if (ok && we) begin
         ref_mem[a / 4] = wd;
         wc_m = wc_m + 16'd1;
      end
      e.port = p;
      e.err = !ok;
      e.chk_data = ok && !we;
      e.data = ok ? ref_mem[a / 4] : 32'd0;
      e.wcnt = wc_m;
      last_m = p;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (im_cs) chk("cs_addr_valid", {31'd0, addr_valid(Address)}, 32'd1);
         if (f_ack || l_ack) begin
            if (f_ack && l_ack) chk("dual_ack", {f_ack, l_ack}, 2'b00);
            else if (exp_q.size() == 0) chk("unexpected_ack", {f_ack, l_ack}, 2'b00);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_port", {31'd0, l_ack}, {31'd0, e.port});
               chk("err", {31'd0, l_ack ? l_err : f_err}, {31'd0, e.err});
               if (e.chk_data) chk("rdata", l_ack ? l_rdata : f_data, e.data);
               chk("wr_count", {16'd0, wr_count}, {16'd0, e.wcnt});
            end
         end
      end
   end

   // One transaction per active port; both active models a simultaneous tie.
   task automatic round(input bit rf, input bit rl, input logic [31:0] fa, input logic [31:0] la,
                        input logic lwe, input logic [31:0] lwd);
      logic first;
      int   lat_exp, cyc;
      bit   fd, ld;
      first = (rf && rl) ? (last_m == PL ? PF : PL) : (rl ? PL : PF);
      if (first == PF) begin
         push_exp(PF, fa, 1'b0, 32'd0);
         if (rl) push_exp(PL, la, lwe, lwd);
      end else begin
         push_exp(PL, la, lwe, lwd);
         if (rf) push_exp(PF, fa, 1'b0, 32'd0);
      end
      lat_exp = (rf ^ rl) ? (addr_valid(first == PL ? la : fa) ? 2 : 1) : 0;
      f_req = rf; l_req = rl; f_addr = fa; l_addr = la; l_we = lwe; l_wdata = lwd;
      fd = !rf; ld = !rl; cyc = 0;
      while (!(fd && ld) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (f_ack && !fd) begin
            fd = 1; f_req = 1'b0;
            if (lat_exp != 0) chk("latency_f", cyc, lat_exp);
         end
         if (l_ack && !ld) begin
            ld = 1; l_req = 1'b0;
            if (lat_exp != 0) chk("latency_l", cyc, lat_exp);
         end
      end
      if (!(fd && ld)) chk("ack_wait", {30'd0, fd, ld}, 32'd3);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return $urandom_range(0, 1022) * 4 + $urandom_range(1, 3);
      if (r == 1) return 32'd4096 + $urandom_range(0, 64) * 4;
      if (r == 2) return 32'd4092;
      return $urandom_range(0, 1023) * 4;
   endfunction

   initial begin
      int acks, cyc;
      for (int i = 0; i < 1024; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem[i] = v;
         ref_mem[i] = v;
      end
      mem[4] = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      reset_n = 1'b0;
      f_req = 0; l_req = 0; l_we = 0; f_addr = 0; l_addr = 0; l_wdata = 0;
      last_m = PL; wc_m = 16'd0;
      repeat (2) @(negedge clk);
      chk("rst_f_ack", {31'd0, f_ack}, 32'd0);
      chk("rst_l_ack", {31'd0, l_ack}, 32'd0);
      chk("rst_f_err", {31'd0, f_err}, 32'd0);
      chk("rst_l_err", {31'd0, l_err}, 32'd0);
      chk("rst_f_data", f_data, 32'd0);
      chk("rst_l_rdata", l_rdata, 32'd0);
      chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_im_cs", {29'd0, im_cs, im_rd, im_wr}, 32'd0);
      chk("rst_address", Address, 32'd0);
      chk("rst_d_in", D_In, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Both ports held from reset: fetch, loader, fetch, loader.
      for (int i = 0; i < 4; i++) push_exp(last_m == PL ? PF : PL, i % 2 ? 32'h104 : 32'h100, 1'b0, 32'd0);
      f_addr = 32'h100; l_addr = 32'h104; l_we = 0; f_req = 1; l_req = 1;
      acks = 0; cyc = 0;
      while (acks < 4 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (f_ack || l_ack) acks++;
      end
      chk("tie_acks", acks, 4);
      f_req = 0; l_req = 0;
      @(negedge clk);

      // Reset while a loader write is in ACCESS.
      l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      chk("abort_in_access", {31'd0, im_cs}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_im_cs", {29'd0, im_cs, im_rd, im_wr}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_wr_count", {16'd0, wr_count}, 32'd0);
      last_m = PL; wc_m = 16'd0;
      @(negedge clk);
      l_req = 0; l_we = 0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_write", mem[16], ref_mem[16]);

      round(1, 0, 32'h10, 32'h0, 0, 32'h0);
      round(0, 1, 32'h0, 32'h20, 1, 32'h12345678);
      round(0, 1, 32'h0, 32'h20, 0, 32'h0);
      round(0, 1, 32'h0, 32'h22, 1, 32'h11111111);
      round(0, 1, 32'h0, 32'd4096, 1, 32'h22222222);
      round(1, 1, 32'd4092, 32'd4092, 1, 32'hA5A5A5A5);

      for (int i = 0; i < 150; i++) begin
         int k;
         k = $urandom_range(0, 2);
         round(k != 1, k != 0, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)), $urandom);
      end

      @(negedge clk);
      force dut.wr_count_q = 16'hFFFF;
      #1;
      release dut.wr_count_q;
      wc_m = 16'hFFFF;
      round(0, 1, 32'h0, 32'h80, 1, 32'h0BADF00D);
      chk("wrap_wr_count", {16'd0, wr_count}, 32'd0);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
